// File: rtl/scr1_dbg_tapc.sv
// JTAG TAP controller for the debug subsystem: 1149.1 state machine, 5-bit IR,
// IDCODE/BYPASS data registers and the strobe/TDO interface to the DMI chains.
module scr1_dbg_tapc #(
  parameter int unsigned IR_WIDTH    = 5,
  parameter logic [31:0] IDCODE_VAL  = 32'h0000_0001,
  parameter int unsigned CH_ID_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  output logic                   tdo_en,
  output logic                   dtm_ch_sel,
  output logic [CH_ID_WIDTH-1:0] dtm_ch_id,
  output logic                   dtm_ch_capture,
  output logic                   dtm_ch_shift,
  output logic                   dtm_ch_update,
  output logic                   dtm_ch_tdi,
  input  logic                   dtm_ch_tdo
);

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI
  } dr_sel_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(5'h1F);

  tap_state_e            state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [31:0]           idcode_sr_q, idcode_sr_d;
  logic                  bypass_q, bypass_d;
  dr_sel_e               dr_sel;

  // TMS-driven next-state decode of the 16-state TAP machine
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:    state_d = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_d = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_d = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  state_d = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_d = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_d = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  state_d = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
      default:    state_d = TAP_TLR;
    endcase
  end

  // Instruction decode from the committed IR; unknown codes fall back to BYPASS
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir_q)
      IR_IDCODE: dr_sel = DR_IDCODE;
      IR_DTMCS:  dr_sel = DR_DTMCS;
      IR_DMI:    dr_sel = DR_DMI;
      IR_BYPASS: dr_sel = DR_BYPASS;
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // IR and data-register capture/shift/update; pause and exit states hold contents
  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    idcode_sr_d = idcode_sr_q;
    bypass_d    = bypass_q;

    if (state_q == TAP_TLR) begin
      ir_d = IR_IDCODE;
    end else if (state_q == TAP_UPD_IR) begin
      ir_d = ir_sr_q;
    end

    if (state_q == TAP_CAP_IR) begin
      ir_sr_d = IR_WIDTH'(2'b01);
    end else if (state_q == TAP_SH_IR) begin
      ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
    end

    if (dr_sel == DR_IDCODE) begin
      if (state_q == TAP_CAP_DR) begin
        idcode_sr_d = IDCODE_VAL;
      end else if (state_q == TAP_SH_DR) begin
        idcode_sr_d = {tdi, idcode_sr_q[31:1]};
      end
    end

    if (dr_sel == DR_BYPASS) begin
      if (state_q == TAP_CAP_DR) begin
        bypass_d = 1'b0;
      end else if (state_q == TAP_SH_DR) begin
        bypass_d = tdi;
      end
    end
  end

  // State and register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TAP_TLR;
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      idcode_sr_q <= idcode_sr_d;
      bypass_q    <= bypass_d;
    end
  end

  // DMI chain select, strobes and forwarded TDI
  always_comb begin
    dtm_ch_sel = (dr_sel == DR_DTMCS) || (dr_sel == DR_DMI);
    dtm_ch_id  = '0;
    if (dr_sel == DR_DTMCS) begin
      dtm_ch_id = CH_ID_WIDTH'(1);
    end else if (dr_sel == DR_DMI) begin
      dtm_ch_id = CH_ID_WIDTH'(2);
    end
    dtm_ch_capture = (state_q == TAP_CAP_DR) && dtm_ch_sel;
    dtm_ch_shift   = (state_q == TAP_SH_DR)  && dtm_ch_sel;
    dtm_ch_update  = (state_q == TAP_UPD_DR) && dtm_ch_sel;
    dtm_ch_tdi     = tdi;
  end

  // TDO source mux and output enable
  always_comb begin
    tdo    = 1'b0;
    tdo_en = (state_q == TAP_SH_IR) || (state_q == TAP_SH_DR);
    if (state_q == TAP_SH_IR) begin
      tdo = ir_sr_q[0];
    end else if (state_q == TAP_SH_DR) begin
      unique case (dr_sel)
        DR_DTMCS, DR_DMI: tdo = dtm_ch_tdo;
        DR_IDCODE:        tdo = idcode_sr_q[0];
        default:          tdo = bypass_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dbg_tapc.sv
// Table-driven bench for the debug TAP controller: per-TCK vectors with expected
// outputs, routed through a scoreboard queue and checked just after the falling edge.
module tb_scr1_dbg_tapc;

  localparam logic [31:0] IDCODE = 32'h4C5A_0E9D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en, dtm_ch_sel, dtm_ch_capture, dtm_ch_shift, dtm_ch_update;
  logic       dtm_ch_tdi;
  logic [1:0] dtm_ch_id;
  logic       dtm_ch_tdo = 1'b0;

  scr1_dbg_tapc #(
    .IR_WIDTH   (5),
    .IDCODE_VAL (IDCODE),
    .CH_ID_WIDTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tms           (tms),
    .tdi           (tdi),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .dtm_ch_sel    (dtm_ch_sel),
    .dtm_ch_id     (dtm_ch_id),
    .dtm_ch_capture(dtm_ch_capture),
    .dtm_ch_shift  (dtm_ch_shift),
    .dtm_ch_update (dtm_ch_update),
    .dtm_ch_tdi    (dtm_ch_tdi),
    .dtm_ch_tdo    (dtm_ch_tdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic       rst_n, tms, tdi, ctdo;
    logic       tdo, en, sel;
    logic [1:0] id;
    logic       cap, sh, upd;
    bit         chk_sel;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_tag  = 0;
  bit   done     = 1'b0;
  logic       es  = 1'b0;
  logic [1:0] eid = 2'd0;

  task automatic pv(input logic r, input logic tm, input logic ti, input logic ct,
                    input logic etdo, input logic een, input logic ecap,
                    input logic esh, input logic eupd, input bit chk);
    vec_t v;
    v.tag = cur_tag; v.rst_n = r; v.tms = tm; v.tdi = ti; v.ctdo = ct;
    v.tdo = etdo; v.en = een; v.sel = es; v.id = eid;
    v.cap = ecap; v.sh = esh; v.upd = eupd; v.chk_sel = chk;
    vecs.push_back(v);
  endtask

  // Full IR scan from Run-Test/Idle back to Run-Test/Idle
  task automatic ir_scan(input logic [4:0] val, input logic nsel, input logic [1:0] nid);
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // RTI
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_DR
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_IR
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // CAP_IR
    for (int k = 0; k < 5; k++)
      pv(1, (k == 4), val[k], 0, (k == 0), 1, 0, 0, 0, 1);
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // EX1_IR
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // UPD_IR
    es  = nsel;
    eid = nid;
  endtask

  // Full DR scan from RTI to RTI, optional Exit1/Pause/Exit2 detour after pause_at bits
  task automatic dr_scan(input int n, input logic [63:0] tdis, input logic [63:0] ctdos,
                         input logic [63:0] exps, input int pause_at);
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // RTI
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_DR
    pv(1, 0, 0, 0, 0, 0, es, 0, 0, 1);  // CAP_DR
    for (int k = 0; k < n; k++) begin
      pv(1, (k == n - 1) || (k == pause_at - 1), tdis[k], ctdos[k], exps[k], 1, 0, es, 0, 1);
      if (k == pause_at - 1) begin
        pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); // EX1_DR
        pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); // PA_DR
        pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); // PA_DR
        pv(1, 0, 1, 1, 0, 0, 0, 0, 0, 1); // EX2_DR
      end
    end
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // EX1_DR
    pv(1, 0, 0, 0, 0, 0, 0, 0, es, 1);  // UPD_DR
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: vector playback did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    logic [63:0] rt, rc;
    vec_t e;
    bit   bad;

    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ((tdo !== 1'b0) || (tdo_en !== 1'b0) || (dtm_ch_sel !== 1'b0) || (dtm_ch_id !== 2'd0) ||
        (dtm_ch_capture !== 1'b0) || (dtm_ch_shift !== 1'b0) || (dtm_ch_update !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset state: tdo=%b en=%b sel=%b id=%0d cap=%b sh=%b upd=%b",
               tdo, tdo_en, dtm_ch_sel, dtm_ch_id, dtm_ch_capture, dtm_ch_shift, dtm_ch_update);
    end

    // reset state
    cur_tag = 0;
    pv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    pv(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);

    // IDCODE read straight out of reset
    cur_tag = 1;
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // TLR -> RTI
    dr_scan(32, 64'd0, 64'd0, {32'd0, IDCODE}, -1);

    // IR <- DMI_ACCESS
    cur_tag = 3;
    ir_scan(5'h11, 1'b1, 2'd2);

    // 41-bit DMI scan: strobes once each, tdi/tdo pass through
    cur_tag = 4;
    rt = {$urandom, $urandom};
    rc = {$urandom, $urandom};
    dr_scan(41, rt, rc, rc, -1);

    // five TMS=1 from SH_DR lands in TLR and restores IDCODE
    cur_tag = 2;
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // RTI
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_DR
    pv(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);   // CAP_DR
    pv(1, 1, 0, 1, 1, 1, 0, 1, 0, 1);   // SH_DR
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // EX1_DR
    pv(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);   // UPD_DR
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_DR
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_IR
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // TLR, IR forced on this edge
    es = 1'b0; eid = 2'd0;
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // TLR -> RTI
    cur_tag = 7;
    dr_scan(32, 64'd0, 64'd0, {32'd0, IDCODE}, 16);

    // explicit and unknown-code bypass
    cur_tag = 5;
    ir_scan(5'h1F, 1'b0, 2'd0);
    dr_scan(4, 64'b1101, 64'b0110, 64'b1010, -1);
    ir_scan(5'h05, 1'b0, 2'd0);
    dr_scan(4, 64'b1101, 64'b1001, 64'b1010, -1);

    // async reset during a partial IR scan of DTMCS
    cur_tag = 6;
    ir_scan(5'h11, 1'b1, 2'd2);
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // RTI
    pv(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_DR
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // SEL_IR
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // CAP_IR
    pv(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);   // SH_IR bit0
    pv(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);   // SH_IR bit1
    pv(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);   // SH_IR bit2
    es = 1'b0; eid = 2'd0;
    pv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    pv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    pv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // TLR -> RTI
    dr_scan(8, 64'd0, 64'hFF, {56'd0, IDCODE[7:0]}, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n      = vecs[i].rst_n;
      tms        = vecs[i].tms;
      tdi        = vecs[i].tdi;
      dtm_ch_tdo = vecs[i].ctdo;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      n_checks++;
      bad = (tdo !== e.tdo) || (tdo_en !== e.en) || (dtm_ch_capture !== e.cap) ||
            (dtm_ch_shift !== e.sh) || (dtm_ch_update !== e.upd) || (dtm_ch_tdi !== e.tdi) ||
            (e.chk_sel && ((dtm_ch_sel !== e.sel) || (dtm_ch_id !== e.id)));
      if (bad) begin
        n_fail++;
        $display("FAIL test%0d vec%0d: got tdo=%b en=%b sel=%b id=%0d cap=%b sh=%b upd=%b chtdi=%b, exp tdo=%b en=%b sel=%b id=%0d cap=%b sh=%b upd=%b chtdi=%b",
                 e.tag, i, tdo, tdo_en, dtm_ch_sel, dtm_ch_id, dtm_ch_capture, dtm_ch_shift,
                 dtm_ch_update, dtm_ch_tdi, e.tdo, e.en, e.sel, e.id, e.cap, e.sh, e.upd, e.tdi);
      end
    end

    done = 1'b1;
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
